// File: rtl/cmd_sched.sv
// cmd_sched: decodes direction bytes from two UART ports, arbitrates them into a
// command FIFO and presents one command at a time to the game controller.
module cmd_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter bit PACE_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a_data,
  input  logic       a_valid,
  input  logic [7:0] b_data,
  input  logic       b_valid,
  input  logic       vs_in,
  output logic [2:0] cmd_code,
  output logic       cmd_src,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [4:0] fifo_level,
  output logic [7:0] drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, PRESENT} state_t;

  function automatic logic [2:0] decode(input logic [7:0] b);
    if (b >= 8'h31 && b <= 8'h35) return b[2:0];
    return 3'd0;
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, v} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [2:0]    dec_a, dec_b;
  logic          ok_a, ok_b;
  logic [2:0]    code_a_p0, code_b_p0;
  logic          vld_a_p0, vld_b_p0;
  logic          rr_b;
  logic          can_push, gnt_a, gnt_b, push, pop;
  logic          drop_a, drop_b;
  logic [3:0]    push_word;
  logic [3:0]    mem_p1 [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          vs_q, tok_q, tok;
  state_t        state, state_n;

  // Stage p0: decode and per-port pending entry
  assign dec_a = decode(a_data);
  assign dec_b = decode(b_data);
  assign ok_a  = (dec_a != 3'd0);
  assign ok_b  = (dec_b != 3'd0);

  // A strobe onto a pending entry that is not leaving this cycle loses the old code
  assign drop_a = a_valid && (!ok_a || (vld_a_p0 && !gnt_a));
  assign drop_b = b_valid && (!ok_b || (vld_b_p0 && !gnt_b));

  // Stage p1: round-robin arbiter (rr_b=1 favours port B) into the FIFO
  assign can_push  = (fifo_level < 5'(FIFO_DEPTH));
  assign gnt_a     = can_push && vld_a_p0 && (!vld_b_p0 || !rr_b);
  assign gnt_b     = can_push && vld_b_p0 && (!vld_a_p0 || rr_b);
  assign push      = gnt_a || gnt_b;
  assign push_word = gnt_b ? {1'b1, code_b_p0} : {1'b0, code_a_p0};

  assign tok = PACE_EN ? tok_q : 1'b1;

  // Stage p2: output presentation FSM
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (tok && fifo_level != 5'd0) begin
          pop     = 1'b1;
          state_n = PRESENT;
        end
      end
      PRESENT: begin
        if (cmd_ready) state_n = IDLE;
      end
    endcase
  end

  assign cmd_valid = (state == PRESENT);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_a_p0   <= 1'b0;
      vld_b_p0   <= 1'b0;
      rr_b       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= 5'd0;
      drop_cnt   <= 8'd0;
      vs_q       <= 1'b1;
      tok_q      <= 1'b0;
      state      <= IDLE;
      cmd_code   <= 3'd0;
      cmd_src    <= 1'b0;
    end else begin
      if (a_valid && ok_a) vld_a_p0 <= 1'b1;
      else if (gnt_a)      vld_a_p0 <= 1'b0;
      if (b_valid && ok_b) vld_b_p0 <= 1'b1;
      else if (gnt_b)      vld_b_p0 <= 1'b0;
      if (vld_a_p0 && vld_b_p0 && can_push) rr_b <= gnt_a;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 5'd1;
        2'b01:   fifo_level <= fifo_level - 5'd1;
        default: fifo_level <= fifo_level;
      endcase
      drop_cnt <= sat_add(drop_cnt, 2'(drop_a) + 2'(drop_b));
      vs_q     <= vs_in;
      // A new frame edge wins over the token being consumed, so it is never lost
      tok_q    <= (vs_in && !vs_q) || (tok_q && !pop);
      state    <= state_n;
      if (pop) begin
        cmd_code <= mem_p1[rd_ptr][2:0];
        cmd_src  <= mem_p1[rd_ptr][3];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (a_valid && ok_a) code_a_p0 <= dec_a;
    if (b_valid && ok_b) code_b_p0 <= dec_b;
    if (push) mem_p1[wr_ptr] <= push_word;
  end

endmodule

// File: tb/tb_cmd_sched.sv
// Bench for cmd_sched: an unpaced instance checked by a scoreboard against a
// queue-level model, and a paced instance exercised frame by frame.
module tb_cmd_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, vs_in;
  logic [2:0] fr_code;
  logic       fr_src, fr_valid, fr_ready;
  logic [4:0] fr_level;
  logic [7:0] fr_drop;
  logic [7:0] pa_data;
  logic       pa_valid;
  logic [2:0] pc_code;
  logic       pc_src, pc_valid, pc_ready;
  logic [4:0] pc_level;
  logic [7:0] pc_drop;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];
  bit rr_m;
  int drop_m;
  bit rdy_rand;

  cmd_sched #(.FIFO_DEPTH(4), .PACE_EN(1'b0)) u_free (
    .clk(clk), .rst(rst), .a_data(a_data), .a_valid(a_valid), .b_data(b_data),
    .b_valid(b_valid), .vs_in(vs_in), .cmd_code(fr_code), .cmd_src(fr_src),
    .cmd_valid(fr_valid), .cmd_ready(fr_ready), .fifo_level(fr_level), .drop_cnt(fr_drop));

  cmd_sched #(.FIFO_DEPTH(4), .PACE_EN(1'b1)) u_paced (
    .clk(clk), .rst(rst), .a_data(pa_data), .a_valid(pa_valid), .b_data(8'h00),
    .b_valid(1'b0), .vs_in(vs_in), .cmd_code(pc_code), .cmd_src(pc_src),
    .cmd_valid(pc_valid), .cmd_ready(pc_ready), .fifo_level(pc_level), .drop_cnt(pc_drop));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int dec(input logic [7:0] b);
    return (b >= 8'h31 && b <= 8'h35) ? int'(b) - 48 : 0;
  endfunction

  function automatic logic [7:0] rbyte();
    if ($urandom_range(0, 3) != 0) return 8'h31 + 8'($urandom_range(0, 4));
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic logic [7:0] bad_byte();
    return 8'h40 + 8'($urandom_range(0, 8'hBF));
  endfunction

  // Model: decodable bytes enter the queue in arrival order; same-cycle ties
  // alternate starting with port A; undecodable bytes only bump the drop count.
  task automatic issue(input bit va, input logic [7:0] da, input bit vb, input logic [7:0] db);
    int ca, cb;
    ca = va ? dec(da) : 0;
    cb = vb ? dec(db) : 0;
    if (va && ca == 0) drop_m = (drop_m < 255) ? drop_m + 1 : 255;
    if (vb && cb == 0) drop_m = (drop_m < 255) ? drop_m + 1 : 255;
    if (ca != 0 && cb != 0) begin
      if (!rr_m) begin exp_q.push_back({1'b0, 3'(ca)}); exp_q.push_back({1'b1, 3'(cb)}); end
      else       begin exp_q.push_back({1'b1, 3'(cb)}); exp_q.push_back({1'b0, 3'(ca)}); end
      rr_m = !rr_m;
    end else if (ca != 0) exp_q.push_back({1'b0, 3'(ca)});
    else if (cb != 0)     exp_q.push_back({1'b1, 3'(cb)});
    a_data = da; a_valid = va; b_data = db; b_valid = vb;
    cyc(1);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic pissue(input logic [7:0] d);
    pa_data = d; pa_valid = 1'b1;
    cyc(1);
    pa_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; pa_valid = 1'b0;
    cyc(2);
    exp_q.delete(); rr_m = 1'b0; drop_m = 0;
    rst = 1'b0;
  endtask

  // One frame: vs_in high for 4 cycles then low; counts accepted paced commands
  task automatic vs_window(output int n, output int code);
    n = 0; code = 0;
    vs_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (pc_valid && pc_ready) begin n++; code = int'(pc_code); end
      if (i == 3) vs_in = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    fr_ready = 1'b1;
    forever begin
      int stall;
      @(posedge clk); #1;
      if (rdy_rand && stall < 2 && $urandom_range(0, 2) == 0) begin
        fr_ready = 1'b0; stall++;
      end else begin
        fr_ready = 1'b1; stall = 0;
      end
    end
  end

  // Scoreboard monitor for the unpaced instance
  logic       pv, pr, psrc;
  logic [2:0] pcode;
  always @(negedge clk) begin
    logic [3:0] e;
    if (rst) begin
      pv = 1'b0; pr = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", int'(fr_valid), 1);
        chk("hold_code", int'(fr_code), int'(pcode));
        chk("hold_src", int'(fr_src), int'(psrc));
      end
      if (pv && pr) chk("idle_gap", int'(fr_valid), 0);
      if (fr_valid && fr_ready) begin
        if (exp_q.size() == 0) chk("unexpected_cmd_queue_size", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("sb_code", int'(fr_code), int'(e[2:0]));
          chk("sb_src", int'(fr_src), int'(e[3]));
        end
      end
      pv = fr_valid; pr = fr_ready; pcode = fr_code; psrc = fr_src;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, code, ga, gb, waitc;
    rst = 1'b1; a_data = 8'h00; b_data = 8'h00; a_valid = 1'b0; b_valid = 1'b0;
    pa_data = 8'h00; pa_valid = 1'b0; vs_in = 1'b0; pc_ready = 1'b0; rdy_rand = 1'b0;
    cyc(1);
    do_reset();
    chk("rst_valid", int'(fr_valid) + int'(pc_valid), 0);
    chk("rst_code", int'(fr_code) + int'(pc_code), 0);
    chk("rst_src", int'(fr_src) + int'(pc_src), 0);
    chk("rst_level", int'(fr_level) + int'(pc_level), 0);
    chk("rst_drop", int'(fr_drop) + int'(pc_drop), 0);

    // Latency N+3, unpaced, ready high
    issue(1'b1, 8'h33, 1'b0, 8'h00);
    cyc(1);
    chk("lat_n2_valid", int'(fr_valid), 0);
    cyc(1);
    chk("lat_n3_valid", int'(fr_valid), 1);
    chk("lat_n3_code", int'(fr_code), 3);
    chk("lat_n3_src", int'(fr_src), 0);
    cyc(1);
    chk("lat_n4_valid", int'(fr_valid), 0);

    // Round-robin ties
    do_reset();
    issue(1'b1, 8'h31, 1'b1, 8'h32);
    cyc(10);
    issue(1'b1, 8'h31, 1'b1, 8'h32);
    cyc(10);
    chk("rr_drained", exp_q.size(), 0);

    // Undecodable bytes and saturating drop count, two per cycle
    do_reset();
    issue(1'b1, 8'h41, 1'b0, 8'h00);
    issue(1'b1, 8'h0D, 1'b0, 8'h00);
    issue(1'b1, 8'h36, 1'b0, 8'h00);
    cyc(3);
    chk("drop3", int'(fr_drop), 3);
    chk("drop3_level", int'(fr_level), 0);
    chk("drop3_valid", int'(fr_valid), 0);
    for (int i = 0; i < 100; i++) issue(1'b1, bad_byte(), 1'b1, bad_byte());
    chk("drop203", int'(fr_drop), 203);
    for (int i = 0; i < 100; i++) issue(1'b1, bad_byte(), 1'b1, bad_byte());
    chk("drop_sat", int'(fr_drop), 255);
    chk("drop_sat_model", int'(fr_drop), drop_m);

    // Randomized traffic with random back-pressure
    do_reset();
    rdy_rand = 1'b1;
    ga = 0; gb = 0;
    for (int i = 0; i < 600; i++) begin
      bit va, vb;
      logic [7:0] da, db;
      va = 1'b0; vb = 1'b0; da = 8'h00; db = 8'h00;
      if (ga == 0) begin va = 1'b1; da = rbyte(); ga = $urandom_range(10, 17); end else ga--;
      if (gb == 0) begin vb = 1'b1; db = rbyte(); gb = $urandom_range(10, 17); end else gb--;
      issue(va, da, vb, db);
    end
    waitc = 0;
    while ((exp_q.size() != 0 || fr_valid) && waitc < 300) begin cyc(1); waitc++; end
    chk("rand_drain_queue", exp_q.size(), 0);
    chk("rand_drop", int'(fr_drop), drop_m);
    chk("rand_level", int'(fr_level), 0);
    rdy_rand = 1'b0;

    // Paced: full queue, held pending, overwrite
    vs_in = 1'b0;
    do_reset();
    pc_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      pissue(8'h35);
      cyc(20);
      chk("full_level", int'(pc_level), (k < 4) ? k : 4);
      chk("full_drop", int'(pc_drop), (k == 6) ? 1 : 0);
      chk("full_valid", int'(pc_valid), 0);
      cyc(978);
    end
    pc_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vs_window(n, code);
      chk("full_drain_count", n, 1);
      chk("full_drain_code", code, 5);
      chk("full_drain_level", int'(pc_level), 4 - k);
    end
    vs_window(n, code);
    chk("full_drain_extra", n, 0);

    // Paced: one command per frame
    do_reset();
    pissue(8'h31); cyc(2);
    pissue(8'h32); cyc(2);
    pissue(8'h33); cyc(5);
    chk("pace_level3", int'(pc_level), 3);
    chk("pace_no_token", int'(pc_valid), 0);
    for (int k = 1; k <= 3; k++) begin
      vs_window(n, code);
      chk("pace_count", n, 1);
      chk("pace_code", code, k);
      chk("pace_level", int'(pc_level), 3 - k);
    end

    // Tokens do not accumulate
    do_reset();
    vs_window(n, code);
    vs_window(n, code);
    pissue(8'h34); cyc(2);
    pissue(8'h32); cyc(10);
    chk("tok_single_level", int'(pc_level), 1);
    chk("tok_single_valid", int'(pc_valid), 0);

    // Reset while presenting, vs_in high through reset
    do_reset();
    pc_ready = 1'b0;
    pissue(8'h34); cyc(2);
    pissue(8'h31); cyc(2);
    pissue(8'h32); cyc(5);
    vs_in = 1'b1;
    cyc(4);
    chk("pres_valid", int'(pc_valid), 1);
    chk("pres_code", int'(pc_code), 4);
    chk("pres_level", int'(pc_level), 2);
    rst = 1'b1;
    cyc(1);
    chk("rst_pres_valid", int'(pc_valid), 0);
    chk("rst_pres_level", int'(pc_level), 0);
    cyc(2);
    rst = 1'b0;
    pissue(8'h35);
    cyc(20);
    chk("post_rst_no_cmd", int'(pc_valid), 0);
    chk("post_rst_level", int'(pc_level), 1);
    vs_in = 1'b0; cyc(3);
    vs_in = 1'b1; cyc(4);
    chk("post_rst_edge_valid", int'(pc_valid), 1);
    chk("post_rst_edge_code", int'(pc_code), 5);
    chk("post_rst_edge_level", int'(pc_level), 0);
    vs_in = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cmd_sched.md
CMD_SCHED -- requirements
Module: cmd_sched

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command queue entries (power of two, 2..16).
REQ-002 Parameter PACE_EN, default 1: 1 = at most one command released per video frame; 0 = unpaced.
REQ-003 clk  input  1  single clock, the video pixel clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 a_data  input  8  received byte, port A (Bluetooth UART).
REQ-006 a_valid  input  1  one-cycle strobe qualifying a_data.
REQ-007 b_data  input  8  received byte, port B (HC-01 UART).
REQ-008 b_valid  input  1  one-cycle strobe qualifying b_data.
REQ-009 vs_in  input  1  video vertical sync, frame pacing reference.
REQ-010 cmd_code  output  3  1 up, 2 down, 3 left, 4 right, 5 confirm.
REQ-011 cmd_src  output  1  0 = port A, 1 = port B.
REQ-012 cmd_valid  output  1  command presented to the game controller.
REQ-013 cmd_ready  input  1  game controller accepts the command.
REQ-014 fifo_level  output  5  current queue occupancy.
REQ-015 drop_cnt  output  8  saturating count of dropped bytes.

Function
REQ-016 Decode: ASCII 0x31..0x35 SHALL map to cmd_code 1..5; any other byte SHALL be discarded and SHALL increment drop_cnt.
REQ-017 Each port SHALL have a one-entry pending register (code + valid), loaded the cycle after its strobe with a decodable byte.
REQ-018 If a strobe arrives while that port's pending entry is valid and not granted that cycle, the new code SHALL overwrite the entry and drop_cnt SHALL increment.
REQ-019 Arbiter: each cycle with fifo_level < FIFO_DEPTH, one valid pending entry SHALL be granted and pushed with its source bit; a grant clears that pending entry.
REQ-020 Both pending valid: round-robin; the port not granted last SHALL win; rr pointer updates only on a contested grant.
REQ-021 Queue full: pending entries SHALL hold; no push; no drop unless REQ-018 applies.
REQ-022 Simultaneous push and pop SHALL leave fifo_level unchanged; ordering strictly FIFO.
REQ-023 Frame token: a rising edge of vs_in (registered compare) SHALL set the token; tokens SHALL NOT accumulate beyond one; with PACE_EN=0 the token is constantly set.
REQ-024 Output FSM, states IDLE and PRESENT. IDLE -> PRESENT when token set and queue non-empty: pop head onto cmd_code/cmd_src, assert cmd_valid, clear token (same edge).
REQ-025 PRESENT: cmd_code, cmd_src, cmd_valid SHALL be held stable until a cycle with cmd_ready=1; that edge -> IDLE, cmd_valid deasserts.
REQ-026 PRESENT with cmd_ready=1 SHALL NOT pop the next entry in the same cycle; minimum one IDLE cycle between commands.
REQ-027 Latency, empty queue, token set: strobe at cycle N -> cmd_valid high at cycle N+3.
REQ-028 drop_cnt SHALL saturate at 255; two drop events in one cycle SHALL add 2 (saturating).

Reset
REQ-029 With rst=1 at a clock edge: cmd_valid=0, cmd_code=0, cmd_src=0, fifo_level=0, drop_cnt=0, pending entries cleared, token cleared, FSM IDLE, rr pointer favours port A.
REQ-030 The vs_in edge register SHALL reset to 1 so vs_in held high through reset produces no spurious token.
REQ-031 Reset during PRESENT or mid-arbitration SHALL discard all queued and presented commands without any cmd_valid glitch.

Verification
REQ-032 PACE_EN=0, cmd_ready=1, a_data=0x33 strobed at N -> cmd_valid=1, cmd_code=3, cmd_src=0 at N+3, low at N+4.
REQ-033 a_data=0x31 and b_data=0x32 strobed same cycle, twice (ties) -> outputs in order A:1, B:2, then B:2, A:1 (round-robin alternation).
REQ-034 PACE_EN=1, three commands queued, vs_in toggled -> exactly one cmd_valid per vs_in rising edge, fifo_level 3->2->1->0.
REQ-035 cmd_ready=0, six bytes 0x35 on port A at 1000-cycle spacing, FIFO_DEPTH=4 -> fifo_level stops at 4, one pending held, sixth strobe overwrites pending, drop_cnt=1.
REQ-036 Bytes 0x41, 0x0D, 0x36 -> no push, drop_cnt=3; 300 invalid bytes -> drop_cnt=255.
REQ-037 rst asserted while cmd_valid=1 and fifo_level=2 -> next cycle cmd_valid=0, fifo_level=0; vs_in high throughout reset -> no command until next vs_in rising edge.
